add_sub_byte_serial: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit.
- Feeds one instance of the 8-bit carry-lookahead slice (cla_gp_8_bit) one byte per cycle, least-significant byte first.
- Ripples the slice carry through a carry register and assembles the full result with flags.
- Sits between the ALU operand register stage and the ALU result mux; trades latency for area against the full-width CLA tree.

---
 rtl/add_sub_byte_serial.sv | 203 ++++++++++++++++++++
 tb/tb_add_sub_byte_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/add_sub_byte_serial.sv
// ---------------------------------------------------------------------------
// add_sub_byte_serial
//   Multi-cycle WIDTH-bit adder/subtractor. One 8-bit carry-lookahead slice
//   processes one byte per cycle, least-significant byte first. The carry
//   between bytes is kept in a register. Once the last byte is done, the
//   unit holds the full result and its flags until the consumer accepts them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid             in_ready   unit can accept a request
//   op_sub     0 = A+B, 1 = A-B          a, b       operands (WIDTH bits)
//   out_valid  result valid              out_ready  consumer accepts result
//   result     sum/difference mod 2^WIDTH
//   carry_out  carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   signed two's-complement overflow
//   zero       result == 0
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla_gp_8_bit
//   8-bit carry-lookahead slice. Produces sum bits plus group
//   generate/propagate so that the caller can form the carry out.
//
// Ports
//   i_a, i_b   byte operands         i_c0   carry in
//   o_s        sum bits              o_g    group generate   o_p  group propagate
// ---------------------------------------------------------------------------
module cla_gp_8_bit (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_c0,
   output logic [7:0] o_s,
   output logic       o_g,
   output logic       o_p
);
   logic [7:0] w_g;    // bit generate
   logic [7:0] w_p;    // bit propagate
   logic [7:0] w_gg;   // prefix generate over bits [i:0]
   logic [7:0] w_pp;   // prefix propagate over bits [i:0]
   logic [8:0] w_c;    // carry into each bit position

   assign w_c[0] = i_c0;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign w_g[gi] = i_a[gi] & i_b[gi];
         assign w_p[gi] = i_a[gi] ^ i_b[gi];
         if (gi == 0) begin : g_first
            assign w_gg[gi] = w_g[gi];
            assign w_pp[gi] = w_p[gi];
         end else begin : g_rest
            assign w_gg[gi] = w_g[gi] | (w_p[gi] & w_gg[gi-1]);
            assign w_pp[gi] = w_p[gi] & w_pp[gi-1];
         end
         // Every carry comes straight from the prefix terms and C0,
         // so no carry waits on the carry of the bit below it.
         assign w_c[gi+1] = w_gg[gi] | (w_pp[gi] & i_c0);
         assign o_s[gi]   = w_p[gi] ^ w_c[gi];
      end
   endgenerate

   assign o_g = w_gg[7];
   assign o_p = w_pp[7];
endmodule

module add_sub_byte_serial #(
   parameter int WIDTH  = 32,
   parameter int NBYTES = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;          // B, already inverted for subtract
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_overflow;
   logic             r_zero;

   logic [7:0]       w_a_bytes [NBYTES];
   logic [7:0]       w_b_bytes [NBYTES];
   logic [7:0]       w_a_byte;
   logic [7:0]       w_b_byte;
   logic [7:0]       w_sum;
   logic             w_g;
   logic             w_p;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_result_next;
   logic             w_last;
   logic             w_accept;

   // Split the operands into bytes, and merge the fresh sum byte into
   // the result so the zero flag can see the full word on the last pass.
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
         assign w_a_bytes[gi] = r_a[gi*8 +: 8];
         assign w_b_bytes[gi] = r_b[gi*8 +: 8];
         assign w_result_next[gi*8 +: 8] =
            (r_cnt == CW'(gi)) ? w_sum : r_result[gi*8 +: 8];
      end
   endgenerate

   assign w_a_byte = w_a_bytes[r_cnt];
   assign w_b_byte = w_b_bytes[r_cnt];

   cla_gp_8_bit u_slice (
      .i_a  (w_a_byte),
      .i_b  (w_b_byte),
      .i_c0 (r_carry),
      .o_s  (w_sum),
      .o_g  (w_g),
      .o_p  (w_p)
   );

   assign w_carry_next = w_g | (w_p & r_carry);
   assign w_last       = (r_cnt == CW'(NBYTES - 1));
   assign w_accept     = in_valid && (r_state == S_IDLE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
         S_BUSY:  if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         if (w_accept) begin
            // Subtract is A + ~B + 1: invert B here and start with carry = 1.
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_cnt   <= '0;
         end else if (r_state == S_BUSY) begin
            r_result <= w_result_next;
            r_carry  <= w_carry_next;
            if (w_last) begin
               r_cnt       <= '0;
               r_carry_out <= w_carry_next;
               // Overflow: the effective operands have the same sign,
               // but the sum has the other sign.
               r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_sum[7] != r_a[WIDTH-1]);
               r_zero      <= (w_result_next == '0);
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
endmodule

// File: tb/tb_add_sub_byte_serial.sv
module tb_add_sub_byte_serial;
   localparam int WIDTH  = 32;
   localparam int NBYTES = WIDTH / 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   int errors = 0;
   int checks = 0;

   add_sub_byte_serial #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {zero, overflow, carry, result}.
   function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic s);
      longint           sx, sy, sr;
      longint unsigned  ux, uy;
      logic [WIDTH-1:0] r;
      logic             c, o, z;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      sr = s ? (sx - sy) : (sx + sy);
      o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      c  = s ? (ux >= uy) : ((ux + uy) >= 64'h1_0000_0000);
      r  = s ? (x - y) : (x + y);
      z  = (r == '0);
      return {z, o, c, r};
   endfunction

   // Entered and left at #1 after a rising edge.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic top, input logic [WIDTH-1:0] eres,
                         input logic ecar, input logic eovf, input logic ezero,
                         input int gap, input int hold);
      int  n;
      bit  seen;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1; a = ta; b = tb; op_sub = top;
      check("in_ready_idle", in_ready, 1'b1);
      @(posedge clk); #1;
      // Scramble the inputs: the unit must have latched them already.
      in_valid = 1'b0; a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1));
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         if (n == 0) check("in_ready_busy", in_ready, 1'b0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
         if (out_valid) seen = 1;
      end
      out_ready = 1'b0;
      check("latency", n, NBYTES);
      repeat (hold) begin
         in_valid = 1'($urandom_range(0, 1));
         check("hold", {out_valid, in_ready, carry_out, overflow, zero, result},
                       {1'b1, 1'b0, ecar, eovf, ezero, eres});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("result", result, eres);
      check("carry_out", carry_out, ecar);
      check("overflow", overflow, eovf);
      check("zero", zero, ezero);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_valid", out_valid, 1'b0);
      check("post_ready", in_ready, 1'b1);
      check("post_result", {carry_out, overflow, zero, result}, {ecar, eovf, ezero, eres});
      $display("op a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d z=%0d",
               ta, tb, top, result, carry_out, overflow, zero);
   endtask

   initial begin
      logic [WIDTH+2:0] m;
      logic [WIDTH-1:0] ra, rb;
      logic             rs;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      #2;
      check("reset_outputs", {out_valid, carry_out, overflow, zero, result}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_in_ready", in_ready, 1'b1);

      // Directed cases with hand-derived expectations.
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1, 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0, 1);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 2, 0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 0);

      // Reset in the 2nd BUSY cycle abandons the operation.
      in_valid = 1'b1; a = 32'h0102_0304; b = 32'h1111_1111; op_sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midop_reset_outputs", {out_valid, carry_out, overflow, zero, result}, '0);
      repeat (6) begin
         @(posedge clk); #1;
         check("midop_no_valid", out_valid, 1'b0);
      end
      rst_n = 1'b1;
      check("midop_in_ready", in_ready, 1'b1);
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 0, 0);

      // Backpressure: 10 cycles of out_ready low with in_valid noise.
      run_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 10);

      // Random operations checked against the reference model.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
         if (i % 7 == 0) rb = ra;
         m = model(ra, rb, rs);
         run_op(ra, rb, rs, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1], m[WIDTH+2],
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
